// File: rtl/multi_display_controller.sv
// Round-robin score display: shows each player's BCD score for a dwell period,
// optionally separated by a blanked gap. Optional macro: LEADING_ZERO_BLANK_EN.
module multi_display_controller #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DWELL_MS    = 2000,
    parameter int unsigned BLANK_MS    = 200
) (
    input  logic                       clk_1khz,
    input  logic                       rst_i,
    input  logic [4*NUM_PLAYERS-1:0]   tens_i,
    input  logic [4*NUM_PLAYERS-1:0]   ones_i,
    input  logic                       hold_i,
    input  logic                       next_i,
    output logic [3:0]                 tens_o,
    output logic [3:0]                 ones_o,
    output logic [2:0]                 player_o,
    output logic                       blank_o
);

    localparam int unsigned CNT_MAX = (DWELL_MS > BLANK_MS) ? DWELL_MS : BLANK_MS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam bit          HAS_GAP = (BLANK_MS != 0);

    localparam logic [0:0] ST_SHOW = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    localparam logic [3:0]       BLANK_DIGIT = 4'hF;
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_MS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_MS == 0) ? 0 : BLANK_MS - 1);
    localparam logic [2:0]       LAST_PLAYER = 3'(NUM_PLAYERS - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d, sel_next;
    logic [3:0]       tens_d, ones_d;
    logic [2:0]       player_d;
    logic             blank_d;
    logic [3:0]       live_tens, live_ones;
    logic [3:0]       shown_tens, shown_ones;
    logic             dwell_done;

    // Pick the live digits of the player currently selected
    always_comb begin
        live_tens = 4'h0;
        live_ones = 4'h0;
        for (int k = 0; k < int'(NUM_PLAYERS); k++) begin
            if (sel_q == 3'(k)) begin
                live_tens = tens_i[4*k +: 4];
                live_ones = ones_i[4*k +: 4];
            end
        end
    end

    // Non-BCD digits render as blank; optional leading-zero suppression on tens
    always_comb begin
        shown_tens = (live_tens > 4'd9) ? BLANK_DIGIT : live_tens;
        shown_ones = (live_ones > 4'd9) ? BLANK_DIGIT : live_ones;
`ifdef LEADING_ZERO_BLANK_EN
        if (live_tens == 4'h0) begin
            shown_tens = BLANK_DIGIT;
        end
`else
`endif
    end

    assign sel_next   = (sel_q == LAST_PLAYER) ? 3'd0 : sel_q + 3'd1;
    assign dwell_done = next_i || (!hold_i && (cnt_q == DWELL_LAST));

    // Next-state and registered-output decode; outputs follow the current phase
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        tens_d   = BLANK_DIGIT;
        ones_d   = BLANK_DIGIT;
        blank_d  = 1'b1;
        player_d = player_o;
        case (state_q)
            ST_SHOW: begin
                tens_d   = shown_tens;
                ones_d   = shown_ones;
                blank_d  = 1'b0;
                player_d = sel_q;
                if (dwell_done) begin
                    cnt_d = '0;
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                    end else begin
                        sel_d = sel_next;
                    end
                end else if (!hold_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    sel_d   = sel_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            state_q  <= ST_SHOW;
            cnt_q    <= '0;
            sel_q    <= 3'd0;
            tens_o   <= BLANK_DIGIT;
            ones_o   <= BLANK_DIGIT;
            player_o <= 3'd0;
            blank_o  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            tens_o   <= tens_d;
            ones_o   <= ones_d;
            player_o <= player_d;
            blank_o  <= blank_d;
        end
    end

endmodule
